// File: rtl/ren_vtx_sort.sv
// ren_vtx_sort: captures a triangle, y-sorts its vertices with a 3-step stable network,
// drops flat-degenerate triangles and hands the sorted set to the setup stage.
module ren_vtx_sort #(
  parameter int P_W     = 22,
  parameter int P_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [6*P_W-1:0]   i_vtx0,
  input  logic [6*P_W-1:0]   i_vtx1,
  input  logic [6*P_W-1:0]   i_vtx2,
  input  logic               i_setup_idle,
  output logic               o_en,
  output logic [6*P_W-1:0]   o_vtx0,
  output logic [6*P_W-1:0]   o_vtx1,
  output logic [6*P_W-1:0]   o_vtx2,
  output logic [P_CNT_W-1:0] o_drop_cnt,
  output logic               o_idle
);
  localparam int VW = 6*P_W;
  typedef enum logic [2:0] {S_IDLE, S_S0, S_S1, S_S2, S_ISSUE, S_BUSY} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] v_q [3];
  logic [VW-1:0] v_d [3];
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic sw01, sw12;
  // Offset-binary key so an unsigned compare orders sign-magnitude y; both zeros map to the midpoint.
  function automatic logic [P_W-1:0] key(input logic [VW-1:0] v);
    logic [P_W-1:0] y;
    y = v[5*P_W-1:4*P_W];
    return ~|y[P_W-2:0] ? {1'b1, {(P_W-1){1'b0}}} :
           y[P_W-1]     ? {1'b0, ~y[P_W-2:0]} : {1'b1, y[P_W-2:0]};
  endfunction
  assign sw01 = key(v_q[0]) > key(v_q[1]);
  assign sw12 = key(v_q[1]) > key(v_q[2]);
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (i_valid) begin
        v_d     = '{i_vtx0, i_vtx1, i_vtx2};
        state_d = S_S0;
      end
      S_S0: begin
        if (sw01) begin v_d[0] = v_q[1]; v_d[1] = v_q[0]; end
        state_d = S_S1;
      end
      S_S1: begin
        if (sw12) begin v_d[1] = v_q[2]; v_d[2] = v_q[1]; end
        state_d = S_S2;
      end
      S_S2: begin
        if (sw01) begin v_d[0] = v_q[1]; v_d[1] = v_q[0]; end
        if (key(v_d[0]) == key(v_d[2])) begin
          cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
          state_d = S_IDLE;
        end else state_d = S_ISSUE;
      end
      S_ISSUE: state_d = i_setup_idle ? S_BUSY : S_ISSUE;
      S_BUSY:  state_d = i_setup_idle ? S_IDLE : S_BUSY;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      v_q     <= '{default: '0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_ready    = state_q == S_IDLE;
  assign o_idle     = state_q == S_IDLE;
  assign o_en       = (state_q == S_ISSUE) & i_setup_idle;
  assign o_vtx0     = v_q[0];
  assign o_vtx1     = v_q[1];
  assign o_vtx2     = v_q[2];
  assign o_drop_cnt = cnt_q;
endmodule

// File: tb/tb_ren_vtx_sort.sv
// tb_ren_vtx_sort: directed and random triangles checked against a stable-sort reference
// model, with a scripted setup-stage idle signal.
module tb_ren_vtx_sort;
  localparam int W  = 22;
  localparam int CW = 4;
  localparam int VW = 6*W;
  logic clk = 0, rstn = 0, i_valid = 0, i_setup_idle = 1;
  logic [VW-1:0] i_vtx0 = '0, i_vtx1 = '0, i_vtx2 = '0;
  logic o_ready, o_en, o_idle;
  logic [VW-1:0] o_vtx0, o_vtx1, o_vtx2;
  logic [CW-1:0] o_drop_cnt;
  int ncmp = 0, nerr = 0, exp_cnt = 0;
  ren_vtx_sort #(.P_W(W), .P_CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_vtx0(i_vtx0), .i_vtx1(i_vtx1), .i_vtx2(i_vtx2), .i_setup_idle(i_setup_idle),
    .o_en(o_en), .o_vtx0(o_vtx0), .o_vtx1(o_vtx1), .o_vtx2(o_vtx2),
    .o_drop_cnt(o_drop_cnt), .o_idle(o_idle));
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Vertex with random x/z/colour and y given as sign and magnitude.
  function automatic logic [VW-1:0] mkv(input bit s, input int unsigned mag);
    logic [VW-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom};
    v[5*W-1:4*W] = {s, mag[W-2:0]};
    return v;
  endfunction
  function automatic logic [VW-1:0] mk(input int y);
    return mkv(y < 0, y < 0 ? -y : y);
  endfunction
  function automatic int yval(input logic [VW-1:0] v);
    int m;
    m = int'(v[5*W-2:4*W]);
    return v[5*W-1] ? -m : m;
  endfunction
  function automatic logic [VW-1:0] rnd_v();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk_v(input logic [VW-1:0] e [3]);
    chk("vtx0", o_vtx0, e[0]);
    chk("vtx1", o_vtx1, e[1]);
    chk("vtx2", o_vtx2, e[2]);
  endtask
  task automatic scramble(input bit vkeep);
    i_vtx0 = rnd_v(); i_vtx1 = rnd_v(); i_vtx2 = rnd_v();
    i_valid = vkeep ? 1'b1 : 1'($urandom_range(0, 1));
  endtask
  // Enter and leave at a negedge with the DUT idle; busy_len >= 1.
  task automatic do_tri(input logic [VW-1:0] a, b, c, input int hold, input int busy_len, input bit vkeep);
    logic [VW-1:0] e [3];
    logic [VW-1:0] t;
    bit deg;
    e = '{a, b, c};
    for (int i = 1; i < 3; i++)
      for (int j = i; j > 0 && yval(e[j-1]) > yval(e[j]); j--) begin
        t = e[j]; e[j] = e[j-1]; e[j-1] = t;
      end
    deg = yval(a) == yval(b) && yval(b) == yval(c);
    if (deg) exp_cnt = exp_cnt == (1 << CW) - 1 ? exp_cnt : exp_cnt + 1;
    i_vtx0 = a; i_vtx1 = b; i_vtx2 = c; i_valid = 1; i_setup_idle = hold == 0;
    #1 chk("ready_cap", VW'(o_ready), VW'(1));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); scramble(vkeep);
      #1 chk("en_sort", VW'(o_en), 0);
      chk("ready_sort", VW'(o_ready), 0);
    end
    @(negedge clk); scramble(vkeep);
    if (deg) begin
      #1 chk("en_deg", VW'(o_en), 0);
      chk("idle_deg", VW'(o_idle), VW'(1));
      chk("drop_cnt", VW'(o_drop_cnt), VW'(exp_cnt));
    end else begin
      for (int k = 0; k < hold; k++) begin
        #1 chk("en_wait", VW'(o_en), 0);
        chk_v(e);
        @(negedge clk); scramble(vkeep);
      end
      i_setup_idle = 1;
      #1 chk("en_issue", VW'(o_en), VW'(1));
      chk_v(e);
      for (int k = 0; k <= busy_len; k++) begin
        @(negedge clk); scramble(vkeep);
        i_setup_idle = k == busy_len;
        #1 chk("en_busy", VW'(o_en), 0);
        chk("ready_busy", VW'(o_ready), 0);
        chk_v(e);
      end
      @(negedge clk); scramble(vkeep);
      #1 chk("ready_done", VW'(o_ready), VW'(1));
      chk_v(e);
      chk("drop_hold", VW'(o_drop_cnt), VW'(exp_cnt));
    end
    i_valid = vkeep;
  endtask
  initial begin
    #12;
    @(negedge clk);
    #1 chk("rst_ready", VW'(o_ready), VW'(1));
    chk("rst_en", VW'(o_en), 0);
    chk("rst_vtx0", o_vtx0, 0);
    chk("rst_cnt", VW'(o_drop_cnt), 0);
    rstn = 1;
    @(negedge clk);
    do_tri(mk(3000), mk(2000), mk(1000), 0, 1, 0);
    do_tri(mk(1000), mkv(1, 0), mk(-2000), 0, 2, 0);
    do_tri(mkv(0, 0), mkv(1, 0), mk(5000), 0, 1, 0);
    do_tri(mk(7000), mk(7000), mk(7000), 0, 1, 0);
    do_tri(mk(-5), mk(9), mk(-5), 10, 6, 0);
    do_tri(mk(4), mk(1), mk(2), 0, 3, 1);
    do_tri(mk(8), mk(8), mk(-8), 2, 1, 0);
    for (int n = 0; n < (1 << CW) + 1; n++) begin
      int y;
      y = $urandom_range(0, 50) - 25;
      do_tri(mk(y), mk(y), (y == 0 && n[0]) ? mkv(1, 0) : mk(y), 0, 1, n[1]);
    end
    for (int n = 0; n < 40; n++)
      do_tri(mk($urandom_range(0, 6) - 3), mk($urandom_range(0, 6) - 3), mk($urandom_range(0, 6) - 3),
             $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    i_vtx0 = mk(3); i_vtx1 = mk(2); i_vtx2 = mk(1); i_valid = 1; i_setup_idle = 1;
    @(negedge clk); i_valid = 0;
    @(negedge clk);
    rstn = 0;
    #1 chk("arst_en", VW'(o_en), 0);
    chk("arst_ready", VW'(o_ready), VW'(1));
    chk("arst_vtx0", o_vtx0, 0);
    chk("arst_vtx1", o_vtx1, 0);
    chk("arst_vtx2", o_vtx2, 0);
    chk("arst_cnt", VW'(o_drop_cnt), 0);
    @(negedge clk); rstn = 1; exp_cnt = 0;
    @(negedge clk);
    do_tri(mk(6), mk(6), mk(6), 0, 1, 0);
    do_tri(mk(1), mk(-1), mk(0), 1, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
